// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO controller driving a single-port 8x8 SRAM, with a one-entry
// show-ahead output register. Pushes and head prefetches share the SRAM port round-robin.
module sram_fifo_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              writeValid,
   output logic              writeReady,
   input  logic [DATA_W-1:0] writeData,
   output logic              readValid,
   input  logic              readReady,
   output logic [DATA_W-1:0] readData,
   output logic [3:0]        count,
   output logic [ADDR_W-1:0] ramAddress,
   output logic              ramWriteEnable,
   output logic              ramChipSelect,
   output logic [DATA_W-1:0] ramDataInp,
   input  logic [DATA_W-1:0] ramDataOutp
);

   typedef enum logic [1:0] {GrantIdle, GrantWrite, GrantRead} grantT;

   localparam logic [ADDR_W:0] RamFull = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] wrPtrQ, rdPtrQ;
   logic [ADDR_W:0]   ramCountQ, ramCountD;
   logic              outValidQ;
   logic [DATA_W-1:0] readDataQ;
   logic              lastWriteQ;
   logic              wantW, wantR;
   grantT             grant;

   // Grant is forced idle during reset so no SRAM op or handshake can leak out.
   always_comb begin
      wantW     = writeValid && (ramCountQ != RamFull);
      wantR     = (ramCountQ != '0) && (!outValidQ || readReady);
      grant     = GrantIdle;
      ramCountD = ramCountQ;
      if (resetN) begin
         if (wantW && wantR) begin
            grant = lastWriteQ ? GrantRead : GrantWrite;
         end else if (wantW) begin
            grant = GrantWrite;
         end else if (wantR) begin
            grant = GrantRead;
         end
      end
      if (grant == GrantWrite) begin
         ramCountD = ramCountQ + 1'b1;
      end else if (grant == GrantRead) begin
         ramCountD = ramCountQ - 1'b1;
      end
   end

   always_comb begin
      ramChipSelect  = 1'b0;
      ramWriteEnable = 1'b0;
      ramAddress     = rdPtrQ;
      writeReady     = 1'b0;
      unique case (grant)
         GrantWrite: begin
            ramChipSelect  = 1'b1;
            ramWriteEnable = 1'b1;
            ramAddress     = wrPtrQ;
            writeReady     = 1'b1;
         end
         GrantRead: ramChipSelect = 1'b1;
         default: ;
      endcase
   end

   assign ramDataInp = writeData;
   assign readValid  = outValidQ;
   assign readData   = readDataQ;
   assign count      = 4'(ramCountQ) + {3'b000, outValidQ};

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wrPtrQ     <= '0;
         rdPtrQ     <= '0;
         ramCountQ  <= '0;
         outValidQ  <= 1'b0;
         readDataQ  <= '0;
         lastWriteQ <= 1'b0;
      end else begin
         ramCountQ <= ramCountD;
         if (grant == GrantWrite) begin
            wrPtrQ <= wrPtrQ + 1'b1;
         end
         // A refill in the same cycle as a pop keeps the head valid without a bubble.
         if (grant == GrantRead) begin
            rdPtrQ    <= rdPtrQ + 1'b1;
            readDataQ <= ramDataOutp;
            outValidQ <= 1'b1;
         end else if (outValidQ && readReady) begin
            outValidQ <= 1'b0;
         end
         if (wantW && wantR) begin
            lastWriteQ <= (grant == GrantWrite);
         end
      end
   end

endmodule
